// File: rtl/mem_arbiter_if.sv
// Shared-memory bus bundle between the two cache controllers,
// the arbiter and the main-memory model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0_strobe;
    logic              req0_rw;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_strobe;
    logic              req1_rw;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              grant0;
    logic              grant1;
    logic              ready0;
    logic              ready1;
    logic [DATA_W-1:0] rdata;
    logic              mem_strobe;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  req0_strobe, req0_rw, req0_addr, req0_wdata,
        input  req1_strobe, req1_rw, req1_addr, req1_wdata,
        input  mem_rdata,
        output grant0, grant1, ready0, ready1, rdata,
        output mem_strobe, mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output req0_strobe, req0_rw, req0_addr, req0_wdata,
        output req1_strobe, req1_rw, req1_addr, req1_wdata,
        output mem_rdata,
        input  grant0, grant1, ready0, ready1, rdata,
        input  mem_strobe, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising I-cache (0) and D-cache (1)
// single-word accesses onto one fixed-latency memory port.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              pick;
    logic              start;
    logic [7:0]        cnt;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy;
    logic              done;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        pick      = last_grant;
        unique case (state)
            S_IDLE: begin
                // On a tie the requester not served last time wins
                if (bus.req0_strobe && bus.req1_strobe) begin
                    start = 1'b1;
                    pick  = ~last_grant;
                end else if (bus.req0_strobe) begin
                    start = 1'b1;
                    pick  = 1'b0;
                end else if (bus.req1_strobe) begin
                    start = 1'b1;
                    pick  = 1'b1;
                end
                if (start) state_nxt = S_ISSUE;
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (cnt == 8'd1) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cnt        <= 8'd0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                last_grant <= pick;
                rw_q       <= pick ? bus.req1_rw    : bus.req0_rw;
                addr_q     <= pick ? bus.req1_addr  : bus.req0_addr;
                wdata_q    <= pick ? bus.req1_wdata : bus.req0_wdata;
            end
            if (state == S_ISSUE) begin
                cnt <= 8'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 8'd1;
            end
            // Memory data is only guaranteed in the final wait cycle
            if (state == S_WAIT && cnt == 8'd1 && !rw_q) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign bus.grant0     = busy & ~last_grant;
    assign bus.grant1     = busy & last_grant;
    assign bus.ready0     = done & ~last_grant;
    assign bus.ready1     = done & last_grant;
    assign bus.mem_strobe = (state == S_ISSUE);
    assign bus.mem_rw     = rw_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses
// plus hand sequences for ties, streaming, strobe drop and reset abort.
module tb_mem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .WAIT_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        who;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [4];

    int total = 0;
    int bad   = 0;

    int cyc;
    int rdy0_q [$];
    int rdy1_q [$];
    int iss_cyc [$];
    int iss_who [$];
    int overlap;
    int gcnt0;
    int gcnt1;
    bit hold0;
    bit hold1;
    bit drop0;
    bit drop1;
    logic [31:0] rd_val;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int at(input int q [$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_mon();
        rdy0_q.delete();
        rdy1_q.delete();
        iss_cyc.delete();
        iss_who.delete();
        overlap = 0;
        gcnt0   = 0;
        gcnt1   = 0;
        drop0   = 1'b0;
        drop1   = 1'b0;
        cyc     = 0;
    endtask

    task automatic idle_inputs();
        bus.req0_strobe = 1'b0;
        bus.req0_rw     = 1'b0;
        bus.req0_addr   = '0;
        bus.req0_wdata  = '0;
        bus.req1_strobe = 1'b0;
        bus.req1_rw     = 1'b0;
        bus.req1_addr   = '0;
        bus.req1_wdata  = '0;
        bus.mem_rdata   = 32'hBAD0BAD0;
    endtask

    // Called #1 after an edge: acts as requesters and memory for one
    // cycle, records what the arbiter shows, then advances a cycle.
    task automatic step();
        if (drop0) begin
            bus.req0_strobe = 1'b0;
            drop0 = 1'b0;
        end
        if (drop1) begin
            bus.req1_strobe = 1'b0;
            drop1 = 1'b0;
        end
        bus.mem_rdata = (cyc == 5) ? rd_val : 32'hBAD0BAD0;
        #1;
        if (bus.mem_strobe) begin
            iss_cyc.push_back(cyc);
            iss_who.push_back(bus.grant1 ? 1 : 0);
        end
        if (bus.grant0 && bus.grant1) overlap++;
        if (bus.grant0) gcnt0++;
        if (bus.grant1) gcnt1++;
        if (bus.ready0) begin
            rdy0_q.push_back(cyc);
            if (!hold0) drop0 = 1'b1;
        end
        if (bus.ready1) begin
            rdy1_q.push_back(cyc);
            if (!hold1) drop1 = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000,
                  32'hDEAD_BEEF, 6, 32'hDEAD_BEEF};
        vt[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678,
                  32'h5555_5555, 6, 32'hDEAD_BEEF};
        vt[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000,
                  32'hCAFE_F00D, 6, 32'hCAFE_F00D};
        vt[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'hA5A5_A5A5,
                  32'h7777_7777, 6, 32'hCAFE_F00D};

        hold0  = 1'b0;
        hold1  = 1'b0;
        rd_val = '0;
        clear_mon();
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({bus.grant0, bus.grant1, bus.ready0,
                             bus.ready1, bus.mem_strobe, bus.mem_rw}), 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", bus.rdata, 0);
        reset = 1'b1;

        // Single accesses from the vector table
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            rd_val = vt[i].mdata;
            if (vt[i].who) begin
                bus.req1_strobe = 1'b1;
                bus.req1_rw     = vt[i].rw;
                bus.req1_addr   = vt[i].addr;
                bus.req1_wdata  = vt[i].wdata;
            end else begin
                bus.req0_strobe = 1'b1;
                bus.req0_rw     = vt[i].rw;
                bus.req0_addr   = vt[i].addr;
                bus.req0_wdata  = vt[i].wdata;
            end
            for (int c = 0; c < 10; c++) begin
                // Inputs moving after the grant must not leak through
                if (c == 2) begin
                    bus.req0_rw    = ~bus.req0_rw;
                    bus.req0_addr  = ~bus.req0_addr;
                    bus.req0_wdata = ~bus.req0_wdata;
                    bus.req1_rw    = ~bus.req1_rw;
                    bus.req1_addr  = ~bus.req1_addr;
                    bus.req1_wdata = ~bus.req1_wdata;
                end
                step();
            end
            chk($sformatf("v%0d_issues", i), 32'(iss_cyc.size()), 1);
            chk($sformatf("v%0d_iss_cyc", i), 32'(at(iss_cyc, 0)), 1);
            chk($sformatf("v%0d_iss_who", i), 32'(at(iss_who, 0)),
                32'(vt[i].who));
            chk($sformatf("v%0d_ready", i),
                32'(vt[i].who ? at(rdy1_q, 0) : at(rdy0_q, 0)),
                32'(vt[i].exp_ready));
            chk($sformatf("v%0d_wrong_ready", i),
                32'(vt[i].who ? rdy0_q.size() : rdy1_q.size()), 0);
            chk($sformatf("v%0d_grant_cycles", i),
                32'(vt[i].who ? gcnt1 : gcnt0), 6);
            chk($sformatf("v%0d_other_grant", i),
                32'(vt[i].who ? gcnt0 : gcnt1), 0);
            chk($sformatf("v%0d_mem_rw", i), 32'(bus.mem_rw),
                32'(vt[i].rw));
            chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vt[i].addr);
            chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata,
                vt[i].wdata);
            chk($sformatf("v%0d_rdata", i), bus.rdata, vt[i].exp_rdata);
            idle_inputs();
        end

        // Strobe dropped in WAIT: access completes, nothing reissued
        clear_mon();
        rd_val = 32'h0BAD_F00D;
        bus.req0_strobe = 1'b1;
        bus.req0_addr   = 32'h0000_0080;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) bus.req0_strobe = 1'b0;
            step();
        end
        chk("drop_ready0", 32'(at(rdy0_q, 0)), 6);
        chk("drop_ready_cnt", 32'(rdy0_q.size()), 1);
        chk("drop_issues", 32'(iss_cyc.size()), 1);
        chk("drop_rdata", bus.rdata, 32'h0BAD_F00D);

        // Reset during WAIT aborts at once; tie afterwards goes to req0
        clear_mon();
        rd_val = 32'h1111_2222;
        bus.req0_strobe = 1'b1;
        bus.req0_addr   = 32'h0000_00C0;
        for (int c = 0; c < 3; c++) step();
        reset = 1'b0;
        #1;
        chk("abort_ctrl", 32'({bus.grant0, bus.grant1, bus.ready0,
                               bus.ready1, bus.mem_strobe}), 0);
        chk("abort_rdata", bus.rdata, 0);
        chk("abort_addr", bus.mem_addr, 0);
        idle_inputs();
        for (int c = 0; c < 6; c++) step();
        chk("abort_no_ready", 32'(rdy0_q.size() + rdy1_q.size()), 0);
        reset = 1'b1;
        clear_mon();
        bus.req0_strobe = 1'b1;
        bus.req1_strobe = 1'b1;
        for (int c = 0; c < 3; c++) step();
        chk("abort_tie_who", 32'(at(iss_who, 0)), 0);
        chk("abort_tie_cyc", 32'(at(iss_cyc, 0)), 1);

        // Both requesting straight out of reset
        do_reset();
        clear_mon();
        bus.req0_strobe = 1'b1;
        bus.req1_strobe = 1'b1;
        for (int c = 0; c < 16; c++) step();
        chk("tie_ready0", 32'(at(rdy0_q, 0)), 6);
        chk("tie_iss1_cyc", 32'(at(iss_cyc, 1)), 8);
        chk("tie_iss1_who", 32'(at(iss_who, 1)), 1);
        chk("tie_ready1", 32'(at(rdy1_q, 0)), 13);
        chk("tie_issues", 32'(iss_cyc.size()), 2);
        chk("tie_overlap", 32'(overlap), 0);

        // Both held continuously: strict alternation
        clear_mon();
        hold0 = 1'b1;
        hold1 = 1'b1;
        bus.req0_strobe = 1'b1;
        bus.req1_strobe = 1'b1;
        for (int c = 0; c < 42; c++) step();
        bus.req0_strobe = 1'b0;
        bus.req1_strobe = 1'b0;
        for (int c = 0; c < 10; c++) step();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_who%0d", k), 32'(at(iss_who, k)),
                32'(k % 2));
            chk($sformatf("rr_cyc%0d", k), 32'(at(iss_cyc, k)),
                32'(1 + 7 * k));
        end
        chk("rr_overlap", 32'(overlap), 0);
        chk("rr_ready0", 32'(rdy0_q.size()), 3);
        chk("rr_ready1", 32'(rdy1_q.size()), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
